// File: rtl/alu_mdu.sv
// Execute-stage ALU with an iterative multiply/divide unit that owns HI/LO.
// ALU path is combinational; MDU takes WIDTH+1 cycles per op (1 for divide-by-zero).
// No flow-control ports: md_start is ignored while busy; the controller must wait.
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       f,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             overflow,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;     // {partial/remainder, multiplier/quotient}
  logic [WIDTH-1:0]    bq_q, bq_d;       // multiplicand or divisor magnitude
  logic                is_div_q, is_div_d;
  logic                sign_q, sign_d;   // negate product / quotient
  logic                rsign_q, rsign_d; // negate remainder (dividend sign)
  logic                dbz_q, dbz_d;
  logic [WIDTH-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic                done_q, done_d, dbzo_q, dbzo_d;

  logic                is_sub;
  logic [WIDTH-1:0]    b_eff, sum;

  // ALU: shared adder for ADD/SUB, result mux and condition flags.
  always_comb begin
    is_sub   = (f == 4'b0110);
    b_eff    = is_sub ? ~b : b;
    sum      = a + b_eff + {{(WIDTH-1){1'b0}}, is_sub};
    y        = '0;
    overflow = 1'b0;
    case (f)
      4'b0000: y = a & b;
      4'b0001: y = a | b;
      4'b0010, 4'b0110: begin
        y        = sum;
        overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      // Direct compares rather than sign of the difference, so overflow cannot corrupt them.
      4'b0011: y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b0100: y = a ^ b;
      4'b0101: y = ~(a | b);
      4'b0111: y = {{(WIDTH-1){1'b0}}, (a < b)};
      4'b1000: y = hi_q;
      4'b1001: y = lo_q;
      default: y = '0;
    endcase
    zero = (y == '0);
  end

  logic                signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]    mag_a, mag_b;
  logic [WIDTH:0]      mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0]  prod_fix;

  // MDU next-state: operand capture, one iteration step per RUN cycle, sign fix-up and HI/LO writes.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    bq_d      = bq_q;
    is_div_d  = is_div_q;
    sign_d    = sign_q;
    rsign_d   = rsign_q;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbzo_d    = 1'b0;

    signed_op = ~md_op[0];
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];
    mag_a     = a_neg ? ('0 - a) : a;
    mag_b     = b_neg ? ('0 - b) : b;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, bq_q} : '0);
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, bq_q};
    prod_fix  = sign_q ? ('0 - acc_q) : acc_q;

    case (state_q)
      S_IDLE: begin
        if (md_start) begin
          is_div_d = md_op[1];
          bq_d     = mag_b;
          count_d  = '0;
          sign_d   = a_neg ^ b_neg;
          rsign_d  = a_neg;
          if (md_op[1] && (b == '0)) begin
            // Keep the raw dividend; it becomes HI unchanged.
            dbz_d   = 1'b1;
            acc_d   = {{WIDTH{1'b0}}, a};
            state_d = S_FIX;
          end else begin
            dbz_d   = 1'b0;
            acc_d   = {{WIDTH{1'b0}}, mag_a};
            state_d = S_RUN;
          end
        end else begin
          if (hi_we) hi_d = a;
          if (lo_we) lo_d = a;
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          // Restoring step: keep the shifted remainder when the trial subtract borrows.
          acc_d = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                  : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        dbzo_d  = dbz_q;
        if (dbz_q) begin
          hi_d = acc_q[WIDTH-1:0];
          lo_d = '1;
        end else if (is_div_q) begin
          lo_d = sign_q  ? ('0 - acc_q[WIDTH-1:0])       : acc_q[WIDTH-1:0];
          hi_d = rsign_q ? ('0 - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // MDU state registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      bq_q     <= '0;
      is_div_q <= 1'b0;
      sign_q   <= 1'b0;
      rsign_q  <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbzo_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      bq_q     <= bq_d;
      is_div_q <= is_div_d;
      sign_q   <= sign_d;
      rsign_q  <= rsign_d;
      dbz_q    <= dbz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbzo_q   <= dbzo_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbzo_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu (WIDTH=32): ALU vectors plus scoreboarded MDU ops.
// MDU expectations come from a behavioural model using native SV arithmetic.
// Outputs are sampled 1 time unit after the rising edge or on the falling edge.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic [3:0]  f = '0;
  logic [31:0] y;
  logic        zero, overflow;
  logic        md_start = 1'b0;
  logic [1:0]  md_op = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;

  alu_mdu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .f(f), .y(y), .zero(zero),
    .overflow(overflow), .md_start(md_start), .md_op(md_op), .hi_we(hi_we),
    .lo_we(lo_we), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv);
    exp_t e;
    int sa, sb_;
    longint p;
    longint unsigned pu;
    sa = av;
    sb_ = bv;
    e.dbz = 1'b0;
    e.hi = '0;
    e.lo = '0;
    case (op)
      2'd0: begin
        p = longint'(sa) * longint'(sb_);
        {e.hi, e.lo} = p;
      end
      2'd1: begin
        pu = {32'b0, av} * {32'b0, bv};
        {e.hi, e.lo} = pu;
      end
      default: begin
        if (bv == 0) begin
          e.dbz = 1'b1;
          e.hi = av;
          e.lo = 32'hFFFFFFFF;
        end else if (op == 2'd3) begin
          e.lo = av / bv;
          e.hi = av % bv;
        end else if (av == 32'h80000000 && bv == 32'hFFFFFFFF) begin
          e.lo = 32'h80000000;
          e.hi = 32'h0;
        end else begin
          e.lo = sa / sb_;
          e.hi = sa % sb_;
        end
      end
    endcase
    return e;
  endfunction

  // Drive one MDU start, push the expected result, and confirm busy after the start edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    md_op = op; a = av; b = bv; md_start = 1'b1;
    sb.push_back(model(op, av, bv));
    @(posedge clk); #1;
    md_start = 1'b0;
    a = $urandom; b = $urandom;   // operands must not matter after start
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_start: busy=%b expected 1", busy);
    end
  endtask

  // Wait (bounded) for done, check latency and pop/compare the scoreboard entry.
  task automatic expect_completion(input string name, input int exp_lat);
    int cyc = 0;
    exp_t e;
    while (done !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timeout: done not seen within %0d cycles", name, cyc);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (cyc != exp_lat) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d edges expected %0d", name, cyc, exp_lat);
    end
    e = sb.pop_front();
    last_exp = e;
    n_tests++;
    if (hi !== e.hi) begin
      n_fail++;
      $display("FAIL %s_hi: got %h expected %h", name, hi, e.hi);
    end
    n_tests++;
    if (lo !== e.lo) begin
      n_fail++;
      $display("FAIL %s_lo: got %h expected %h", name, lo, e.lo);
    end
    n_tests++;
    if (div_by_zero !== e.dbz || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_flags: dbz=%b busy=%b expected dbz=%b busy=0", name, div_by_zero, busy, e.dbz);
    end
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b0 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_pulse: done=%b dbz=%b expected 0 0 one cycle later", name, done, div_by_zero);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b dbz=%b hi=%h lo=%h expected all 0",
               busy, done, div_by_zero, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        ov;
  } alu_vec_t;

  task automatic test_alu();
    alu_vec_t v[$];
    v.push_back('{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1});
    v.push_back('{4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0});
    v.push_back('{4'b0011, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0});
    v.push_back('{4'b0111, 32'h80000000, 32'h00000001, 32'h00000000, 1'b0});
    v.push_back('{4'b0011, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0});
    v.push_back('{4'b0111, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0});
    v.push_back('{4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1});
    v.push_back('{4'b0110, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0});
    v.push_back('{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0});
    v.push_back('{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0});
    v.push_back('{4'b0001, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0});
    v.push_back('{4'b0100, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1'b0});
    v.push_back('{4'b0101, 32'hF0F0F0F0, 32'h0F0F0000, 32'h00000F0F, 1'b0});
    v.push_back('{4'b1010, 32'h00001234, 32'h00005678, 32'h00000000, 1'b0});
    v.push_back('{4'b1000, 32'h00001234, 32'h00005678, 32'h00000000, 1'b0});
    foreach (v[i]) begin
      @(negedge clk);
      f = v[i].f; a = v[i].a; b = v[i].b;
      #1;
      n_tests++;
      if (y !== v[i].y || overflow !== v[i].ov || zero !== (v[i].y == 32'h0)) begin
        n_fail++;
        $display("FAIL alu_vec%0d f=%b: y=%h ov=%b zero=%b expected y=%h ov=%b zero=%b",
                 i, v[i].f, y, overflow, zero, v[i].y, v[i].ov, (v[i].y == 32'h0));
      end
    end
    f = 4'b0000;
  endtask

  task automatic test_multiply();
    issue(2'b00, 32'hFFFFFFFD, 32'h00000007);
    expect_completion("mult", 33);
    issue(2'b01, 32'hFFFFFFFD, 32'h00000007);
    expect_completion("multu", 33);
    @(negedge clk);
    f = 4'b1001;
    #1;
    n_tests++;
    if (y !== last_exp.lo) begin
      n_fail++;
      $display("FAIL mflo_path: y=%h expected %h", y, last_exp.lo);
    end
    f = 4'b1000;
    #1;
    n_tests++;
    if (y !== last_exp.hi) begin
      n_fail++;
      $display("FAIL mfhi_path: y=%h expected %h", y, last_exp.hi);
    end
    f = 4'b0000;
  endtask

  task automatic test_divide();
    issue(2'b10, 32'hFFFFFFF9, 32'h00000002);
    expect_completion("div_neg", 33);
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
    expect_completion("div_minneg", 33);
    issue(2'b11, 32'h00000007, 32'h00000000);
    expect_completion("divu_by_zero", 1);
    issue(2'b10, 32'hFFFFFFF0, 32'h00000000);
    expect_completion("div_by_zero", 1);
    issue(2'b10, 32'h00000064, 32'hFFFFFFF9);
    expect_completion("div_pos_neg", 33);
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] av, bv;
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom_range(0, 3));
      av = $urandom;
      bv = (i % 4 == 3) ? 32'h0 : ((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
      issue(op, av, bv);
      expect_completion("random", (op[1] && bv == 32'h0) ? 1 : 33);
    end
  endtask

  task automatic test_handshake();
    issue(2'b00, 32'h00000123, 32'hFFFFF456);
    repeat (5) @(posedge clk);
    @(negedge clk);
    md_start = 1'b1; md_op = 2'b11; hi_we = 1'b1; lo_we = 1'b1; a = 32'h00001234; b = 32'h0;
    @(posedge clk); #1;
    md_start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    expect_completion("busy_ignore", 27);
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; a = 32'h0000ABCD;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    n_tests++;
    if (hi !== 32'h0000ABCD || lo !== 32'h0000ABCD) begin
      n_fail++;
      $display("FAIL mthi_mtlo: hi=%h lo=%h expected 0000abcd 0000abcd", hi, lo);
    end
    // A write request alongside an accepted start must be dropped.
    @(negedge clk);
    md_start = 1'b1; md_op = 2'b01; hi_we = 1'b1; lo_we = 1'b1; a = 32'h00000009; b = 32'h00000002;
    sb.push_back(model(2'b01, 32'h00000009, 32'h00000002));
    @(posedge clk); #1;
    md_start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    n_tests++;
    if (hi !== 32'h0000ABCD || lo !== 32'h0000ABCD) begin
      n_fail++;
      $display("FAIL we_with_start: hi=%h lo=%h expected 0000abcd 0000abcd", hi, lo);
    end
    expect_completion("we_with_start_op", 33);
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; a = 32'h0000ABCD;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    md_start = 1'b1; md_op = 2'b10; a = 32'h00000064; b = 32'h00000003;
    @(posedge clk); #1;
    md_start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", busy, done, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: busy=%b done=%b expected 0 0", busy, done);
    end
    issue(2'b01, 32'h00000003, 32'h00000005);
    expect_completion("multu_after_reset", 33);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_multiply();
    test_divide();
    test_random();
    test_handshake();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
